conv2d_engine: RTL

- 3x3 2D convolution datapath/sequencer directly downstream of the conv MMIO controller.
- Consumes the controller's start pulse, soft-reset pulse and the four scalar offset/dimension registers.
- Reads weights and the input feature map over a single-outstanding word memory port, accumulates, and writes the output feature map.
- Reports idle/done status back to the controller.

---
 rtl/conv2d_engine_if.sv | 26 ++
 rtl/conv2d_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_engine_if.sv
// Word-wide memory port between the conv engine (master) and memory (slave).
//   req_valid/req_ready : request handshake, accepted when both high
//   we/addr/wdata       : request payload, held stable until accepted
//   rdata/rvalid        : read return, exactly one rvalid per accepted read
interface conv2d_engine_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (
    output req_valid, we, addr, wdata,
    input  req_ready, rdata, rvalid
  );

  modport slave (
    input  req_valid, we, addr, wdata,
    output req_ready, rdata, rvalid
  );
endinterface

// File: rtl/conv2d_engine.sv
// 3x3 2D convolution sequencer: loads 9 weights, then for every output pixel
// reads the in-range IFM taps, multiply-accumulates and writes the OFM word.
//   clk, rst             : clock, asynchronous active-low reset
//   conv_start_i/rst_i   : start and synchronous soft-reset pulses
//   conv_*_offset_i      : IFM/OFM/weight base word addresses, fm_dim = N
//   conv_idle_o/done_o   : idle level, one-cycle completion pulse
//   mem                  : single-outstanding word memory port (master)
module conv2d_engine #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            conv_start_i,
  input  logic            conv_rst_i,
  input  logic [31:0]     conv_ifm_offset_i,
  input  logic [31:0]     conv_ofm_offset_i,
  input  logic [31:0]     conv_fm_dim_i,
  input  logic [31:0]     conv_wt_offset_i,
  output logic            conv_idle_o,
  output logic            conv_done_o,
  conv2d_engine_if.master mem
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_WT, S_FETCH, S_WRITE, S_DONE} state_t;

  state_t          state_q;
  logic [31:0]     ifm_q, ofm_q, wt_base_q;
  logic [15:0]     n_q, r_q, c_q;
  logic [3:0]      k_q;
  logic [DW-1:0]   acc_q;
  logic [DW-1:0]   wt_q [0:8];
  logic            rd_wait_q;   // accepted read whose rvalid is still owed
  logic            drain_q;     // swallow one rvalid left over from a soft reset
  logic            pend_q;      // start accepted while draining

  logic [1:0]        ki_c, kj_c;
  logic [17:0]       row_c, col_c;
  logic              tap_in_c, tap_adv_c, go_c, last_px_c, c_wrap_c;
  logic [31:0]       ifm_addr_c, ofm_addr_c, launch_wt_c;
  logic [15:0]       launch_n_c;
  logic signed [DW-1:0] prod_c;
  logic [DW-1:0]     tap_acc_c;
  logic              unused_c;

  assign unused_c = ^conv_fm_dim_i[31:16];

  // Tap geometry, addresses and the accumulate step
  always_comb begin
    ki_c = 2'd2;
    if (k_q < 4'd3)      ki_c = 2'd0;
    else if (k_q < 4'd6) ki_c = 2'd1;
    kj_c = 2'(k_q - {1'b0, ki_c, 1'b0} - {2'b00, ki_c});
    // Offset by -1 in unsigned arithmetic: row -1 wraps high and fails the bound test
    row_c = {2'b00, r_q} + {16'd0, ki_c} - 18'd1;
    col_c = {2'b00, c_q} + {16'd0, kj_c} - 18'd1;
    tap_in_c   = (row_c < {2'b00, n_q}) && (col_c < {2'b00, n_q});
    ifm_addr_c = ifm_q + (32'(row_c[15:0]) * 32'(n_q)) + 32'(col_c[15:0]);
    ofm_addr_c = ofm_q + (32'(r_q) * 32'(n_q)) + 32'(c_q);
    prod_c     = $signed(mem.rdata) * $signed(wt_q[k_q]);
    tap_adv_c  = rd_wait_q ? mem.rvalid : (!mem.req_valid && !tap_in_c);
    tap_acc_c  = rd_wait_q ? (acc_q + prod_c) : acc_q;
    last_px_c  = (r_q == n_q - 16'd1) && (c_q == n_q - 16'd1);
    c_wrap_c   = (c_q == n_q - 16'd1);
    go_c       = (state_q == S_IDLE) &&
                 (pend_q ? mem.rvalid : (conv_start_i && (!drain_q || mem.rvalid)));
    launch_n_c  = pend_q ? n_q : conv_fm_dim_i[15:0];
    launch_wt_c = pend_q ? wt_base_q : conv_wt_offset_i;
  end

  // Sequencer, datapath registers and memory request outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ifm_q         <= '0;
      ofm_q         <= '0;
      wt_base_q     <= '0;
      n_q           <= '0;
      r_q           <= '0;
      c_q           <= '0;
      k_q           <= '0;
      acc_q         <= '0;
      for (int i = 0; i < 9; i++) wt_q[i] <= '0;
      rd_wait_q     <= 1'b0;
      drain_q       <= 1'b0;
      pend_q        <= 1'b0;
      conv_idle_o   <= 1'b1;
      conv_done_o   <= 1'b0;
      mem.req_valid <= 1'b0;
      mem.we        <= 1'b0;
      mem.addr      <= '0;
      mem.wdata     <= '0;
    end else if (conv_rst_i) begin
      state_q       <= S_IDLE;
      r_q           <= '0;
      c_q           <= '0;
      k_q           <= '0;
      acc_q         <= '0;
      rd_wait_q     <= 1'b0;
      pend_q        <= 1'b0;
      conv_idle_o   <= 1'b1;
      conv_done_o   <= 1'b0;
      mem.req_valid <= 1'b0;
      mem.we        <= 1'b0;
      // A read owed now (or accepted this very cycle) must still be swallowed
      drain_q <= (rd_wait_q && !mem.rvalid) ||
                 (mem.req_valid && mem.req_ready && !mem.we) ||
                 (drain_q && !mem.rvalid);
    end else begin
      conv_done_o <= 1'b0;
      if (mem.req_valid && mem.req_ready) begin
        mem.req_valid <= 1'b0;
        mem.we        <= 1'b0;
        if (!mem.we) rd_wait_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (drain_q && mem.rvalid) drain_q <= 1'b0;
          if (conv_start_i && !pend_q) begin
            ifm_q     <= conv_ifm_offset_i;
            ofm_q     <= conv_ofm_offset_i;
            wt_base_q <= conv_wt_offset_i;
            n_q       <= conv_fm_dim_i[15:0];
          end
          if (go_c) begin
            pend_q      <= 1'b0;
            conv_idle_o <= 1'b0;
            r_q         <= '0;
            c_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            rd_wait_q   <= 1'b0;
            if (launch_n_c == 16'd0) begin
              state_q     <= S_DONE;
              conv_done_o <= 1'b1;
            end else begin
              state_q       <= S_LOAD_WT;
              mem.req_valid <= 1'b1;
              mem.we        <= 1'b0;
              mem.addr      <= AW'(launch_wt_c);
            end
          end else if (conv_start_i && !pend_q) begin
            pend_q      <= 1'b1;
            conv_idle_o <= 1'b0;
          end
        end
        S_LOAD_WT: begin
          if (rd_wait_q && mem.rvalid) begin
            wt_q[k_q] <= mem.rdata;
            rd_wait_q <= 1'b0;
            if (k_q == 4'd8) begin
              state_q <= S_FETCH;
              k_q     <= '0;
              acc_q   <= '0;
              r_q     <= '0;
              c_q     <= '0;
            end else begin
              k_q           <= k_q + 4'd1;
              mem.req_valid <= 1'b1;
              mem.addr      <= AW'(wt_base_q + 32'(k_q) + 32'd1);
            end
          end
        end
        S_FETCH: begin
          if (!rd_wait_q && !mem.req_valid && tap_in_c) begin
            mem.req_valid <= 1'b1;
            mem.we        <= 1'b0;
            mem.addr      <= AW'(ifm_addr_c);
          end else if (tap_adv_c) begin
            rd_wait_q <= 1'b0;
            acc_q     <= tap_acc_c;
            if (k_q == 4'd8) begin
              state_q       <= S_WRITE;
              mem.req_valid <= 1'b1;
              mem.we        <= 1'b1;
              mem.addr      <= AW'(ofm_addr_c);
              mem.wdata     <= tap_acc_c;
            end else begin
              k_q <= k_q + 4'd1;
            end
          end
        end
        S_WRITE: begin
          if (mem.req_valid && mem.req_ready) begin
            if (c_wrap_c) begin
              c_q <= '0;
              r_q <= r_q + 16'd1;
            end else begin
              c_q <= c_q + 16'd1;
            end
            if (last_px_c) begin
              state_q     <= S_DONE;
              conv_done_o <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              k_q     <= '0;
              acc_q   <= '0;
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          conv_idle_o <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
